// File: rtl/grf_wr_arbiter_pkg.sv
// Shared widths and constants for the register-file write arbiter.
package grf_wr_arbiter_pkg;

  localparam int GRF_AW = 5;
  localparam int GRF_DW = 32;

  // Register 0 is hardwired to zero; writes to it are dropped.
  localparam logic [GRF_AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/grf_wq_fifo.sv
// Circular write queue for MDU results. Each entry carries a valid bit so
// that a newer pipeline write can kill it in place without disturbing order.
module grf_wq_fifo
  import grf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = GRF_AW,
  parameter int DW    = GRF_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic [DW-1:0]            push_pc,
  input  logic                     pop,
  input  logic                     kill,
  input  logic [AW-1:0]            kill_addr,
  input  logic [AW-1:0]            q1_addr,
  input  logic [AW-1:0]            q2_addr,
  output logic                     empty,
  output logic                     head_vld,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [DW-1:0]            head_pc,
  output logic [DEPTH-1:0]         q1_hit,
  output logic [DEPTH-1:0]         q2_hit,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    pc_q   [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Queue state: kill first, then pop clears the head, then push sets the
  // tail, so a push into the slot being popped (full case) keeps its valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && addr_q[i] == kill_addr) vld[i] <= 1'b0;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push) begin
        vld[wr_ptr]    <= 1'b1;
        addr_q[wr_ptr] <= push_addr;
        data_q[wr_ptr] <= push_data;
        pc_q[wr_ptr]   <= push_pc;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Per-entry address match; only live entries can match since pop and
  // kill both clear the valid bit.
  always_comb begin
    q1_hit = '0;
    q2_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q1_hit[i] = vld[i] && (addr_q[i] == q1_addr);
      q2_hit[i] = vld[i] && (addr_q[i] == q2_addr);
    end
  end

  assign empty     = (count == '0);
  assign head_vld  = vld[rd_ptr];
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_pc   = pc_q[rd_ptr];

endmodule

// File: rtl/grf_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, queued
// MDU results drain in order, and an MDU result bypasses straight to the
// port when nothing else wants it. Also produces pending-write flags.
module grf_wr_arbiter
  import grf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = GRF_AW,
  parameter int DW    = GRF_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  input  logic [AW-1:0]          wb_addr,
  input  logic [DW-1:0]          wb_data,
  input  logic [DW-1:0]          wb_pc,
  input  logic                   md_valid,
  output logic                   md_ready,
  input  logic [AW-1:0]          md_addr,
  input  logic [DW-1:0]          md_data,
  input  logic [DW-1:0]          md_pc,
  output logic                   grf_we,
  output logic [AW-1:0]          grf_a3,
  output logic [DW-1:0]          grf_wd,
  output logic [DW-1:0]          grf_pc,
  input  logic [AW-1:0]          q1_addr,
  input  logic [AW-1:0]          q2_addr,
  output logic                   q1_pend,
  output logic                   q2_pend,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic             empty;
  logic             head_vld;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;
  logic [DW-1:0]    head_pc;
  logic [DEPTH-1:0] q1_hit;
  logic [DEPTH-1:0] q2_hit;
  logic             wb_go;
  logic             pop;
  logic             bypass;
  logic             push;
  logic             md_xfer;

  // Arbitration decisions; a zero-address writeback does not claim the port.
  always_comb begin
    wb_go    = !reset && wb_valid && (wb_addr != ZR);
    pop      = !reset && !wb_go && !empty;
    bypass   = !reset && !wb_go && empty && md_valid && (md_addr != ZR);
    md_ready = !reset && ((q_count < CW'(DEPTH)) || pop);
    md_xfer  = md_valid && md_ready;
    push     = md_xfer && !bypass && (md_addr != ZR);
  end

  // Write-port mux in priority order; killed head entries pop silently.
  always_comb begin
    grf_we = 1'b0;
    grf_a3 = '0;
    grf_wd = '0;
    grf_pc = '0;
    if (wb_go) begin
      grf_we = 1'b1;
      grf_a3 = wb_addr;
      grf_wd = wb_data;
      grf_pc = wb_pc;
    end else if (pop) begin
      if (head_vld) begin
        grf_we = 1'b1;
        grf_a3 = head_addr;
        grf_wd = head_data;
        grf_pc = head_pc;
      end
    end else if (bypass) begin
      grf_we = 1'b1;
      grf_a3 = md_addr;
      grf_wd = md_data;
      grf_pc = md_pc;
    end
  end

  // Pending flags: live queue entries plus a result being enqueued now.
  always_comb begin
    q1_pend = !reset && (q1_addr != ZR) &&
              ((|q1_hit) || (push && md_addr == q1_addr));
    q2_pend = !reset && (q2_addr != ZR) &&
              ((|q2_hit) || (push && md_addr == q2_addr));
  end

  grf_wq_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (md_addr),
    .push_data (md_data),
    .push_pc   (md_pc),
    .pop       (pop),
    .kill      (wb_go),
    .kill_addr (wb_addr),
    .q1_addr   (q1_addr),
    .q2_addr   (q2_addr),
    .empty     (empty),
    .head_vld  (head_vld),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_pc   (head_pc),
    .q1_hit    (q1_hit),
    .q2_hit    (q2_hit),
    .count     (q_count)
  );

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Directed bench for grf_wr_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_grf_wr_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] wb_pc;
  logic          md_valid;
  logic          md_ready;
  logic [AW-1:0] md_addr;
  logic [DW-1:0] md_data;
  logic [DW-1:0] md_pc;
  logic          grf_we;
  logic [AW-1:0] grf_a3;
  logic [DW-1:0] grf_wd;
  logic [DW-1:0] grf_pc;
  logic [AW-1:0] q1_addr;
  logic [AW-1:0] q2_addr;
  logic          q1_pend;
  logic          q2_pend;
  logic [2:0]    q_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] regs [32];

  always #5 clk = ~clk;

  grf_wr_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_pc    (wb_pc),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_addr  (md_addr),
    .md_data  (md_data),
    .md_pc    (md_pc),
    .grf_we   (grf_we),
    .grf_a3   (grf_a3),
    .grf_wd   (grf_wd),
    .grf_pc   (grf_pc),
    .q1_addr  (q1_addr),
    .q2_addr  (q2_addr),
    .q1_pend  (q1_pend),
    .q2_pend  (q2_pend),
    .q_count  (q_count)
  );

  // Shadow register file built from the write port.
  always @(posedge clk) begin
    if (grf_we) regs[grf_a3] <= grf_wd;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0; md_pc = '0;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_data = d; wb_pc = 32'h400 + 32'(a);
  endtask

  task automatic md(input logic [AW-1:0] a, input logic [DW-1:0] d);
    md_valid = 1'b1; md_addr = a; md_data = d; md_pc = 32'h800 + 32'(a);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    idle();
    q1_addr = '0;
    q2_addr = '0;
    reset = 1'b1;
    md(5'd5, 32'h55);
    tick();
    @(negedge clk);
    chk("rst_ready", md_ready, 0);
    chk("rst_we", grf_we, 0);
    chk("rst_count", q_count, 0);
    chk("rst_pend", q1_pend, 0);
    tick();
    reset = 1'b0;
    idle();
    tick();

    // Bypass straight to the port
    md(5'd8, 32'h1234);
    md_pc = 32'h100;
    @(negedge clk);
    chk("byp_we", grf_we, 1);
    chk("byp_a3", grf_a3, 8);
    chk("byp_wd", grf_wd, 32'h1234);
    chk("byp_pc", grf_pc, 32'h100);
    chk("byp_ready", md_ready, 1);
    tick();
    idle();
    @(negedge clk);
    chk("byp_count", q_count, 0);
    chk("byp_we_after", grf_we, 0);
    tick();

    // Conflict: wb wins, md queued
    q1_addr = 5'd9;
    q2_addr = 5'd3;
    wb(5'd3, 32'hAAAA);
    md(5'd9, 32'hBBBB);
    @(negedge clk);
    chk("cf_a3", grf_a3, 3);
    chk("cf_wd", grf_wd, 32'hAAAA);
    chk("cf_ready", md_ready, 1);
    chk("cf_pend1", q1_pend, 1);
    chk("cf_pend2", q2_pend, 0);
    tick();
    idle();
    @(negedge clk);
    chk("cf_count1", q_count, 1);
    chk("cf_we2", grf_we, 1);
    chk("cf_a3_2", grf_a3, 9);
    chk("cf_wd2", grf_wd, 32'hBBBB);
    chk("cf_pc2", grf_pc, 32'h809);
    chk("cf_pend_drain", q1_pend, 1);
    tick();
    @(negedge clk);
    chk("cf_count0", q_count, 0);
    chk("cf_pend_clr", q1_pend, 0);
    tick();

    // Full: wb holds the port for 6 cycles while md offers 10..14
    q1_addr = '0;
    q2_addr = '0;
    for (int i = 0; i < 6; i++) begin
      wb(5'd4, 32'(i));
      md(5'(10 + (i < 4 ? i : 4)), 32'hA0 + 32'(i < 4 ? i : 4));
      @(negedge clk);
      chk("full_ready", md_ready, (i < 4) ? 1 : 0);
      chk("full_count", q_count, (i < 4) ? i : 4);
      tick();
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) md_valid = 1'b0;
      @(negedge clk);
      chk("drain_we", grf_we, 1);
      chk("drain_a3", grf_a3, 10 + i);
      chk("drain_wd", grf_wd, 32'hA0 + 32'(i));
      chk("drain_count", q_count, (i == 0) ? 4 : 5 - i);
      if (i == 0) chk("drain_ready", md_ready, 1);
      tick();
    end
    idle();
    @(negedge clk);
    chk("drain_done_we", grf_we, 0);
    chk("drain_done_cnt", q_count, 0);
    tick();

    // Kill: queued md 7 overridden by newer wb 7
    q1_addr = 5'd7;
    wb(5'd3, 32'h1);
    md(5'd7, 32'h7777);
    tick();
    idle();
    wb(5'd7, 32'h5555);
    @(negedge clk);
    chk("kill_a3", grf_a3, 7);
    chk("kill_wd", grf_wd, 32'h5555);
    chk("kill_pend_pre", q1_pend, 1);
    chk("kill_count", q_count, 1);
    tick();
    idle();
    @(negedge clk);
    chk("kill_pend_post", q1_pend, 0);
    chk("kill_pop_we", grf_we, 0);
    chk("kill_pop_cnt", q_count, 1);
    tick();
    @(negedge clk);
    chk("kill_empty", q_count, 0);
    chk("kill_we_idle", grf_we, 0);
    tick();
    chk("kill_reg7", regs[7], 32'h5555);

    // Zero register
    q1_addr = '0;
    wb(5'd0, 32'h9999);
    md(5'd0, 32'hFFFF);
    @(negedge clk);
    chk("z_we", grf_we, 0);
    chk("z_ready", md_ready, 1);
    chk("z_pend", q1_pend, 0);
    chk("z_count", q_count, 0);
    tick();
    idle();
    @(negedge clk);
    chk("z_count_after", q_count, 0);
    chk("z_reg0", regs[0], 0);
    tick();

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      wb(5'd4, 32'h40 + 32'(i));
      md(5'(20 + i), 32'h200 + 32'(i));
      tick();
    end
    idle();
    q1_addr = 5'd20;
    q2_addr = 5'd22;
    @(negedge clk);
    chk("mq_count", q_count, 3);
    chk("mq_pend_pre", q1_pend, 1);
    reset = 1'b1;
    md(5'd23, 32'h2323);
    @(negedge clk);
    chk("mq_rst_ready", md_ready, 0);
    chk("mq_rst_we", grf_we, 0);
    chk("mq_rst_pend", q1_pend, 0);
    tick();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mq_post_count", q_count, 0);
      chk("mq_post_we", grf_we, 0);
      chk("mq_post_pend1", q1_pend, 0);
      chk("mq_post_pend2", q2_pend, 0);
      tick();
    end
    chk("mq_reg20", regs[20], 0);
    chk("mq_reg21", regs[21], 0);
    chk("mq_reg22", regs[22], 0);
    chk("mq_reg23", regs[23], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_wr_arbiter.md
Name: grf_wr_arbiter

Overview:
- Shares the register file's single write port between two requesters.
- Requester 1 is the main pipeline writeback (W stage, always wins).
- Requester 2 is the multi-cycle multiply/divide unit (MDU) result path, buffered in a small FIFO.
- Sits between the W stage / MDU and the register file; also drives the pending-write flags the hazard unit needs to stall readers of not-yet-written registers.

Parameters:
- DEPTH, 4, MDU write-queue entries; power of two, >= 2.
- AW, 5, register address width.
- DW, 32, data and PC width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  pipeline writeback request this cycle
- wb_addr  in  AW  pipeline destination register
- wb_data  in  DW  pipeline write data
- wb_pc  in  DW  PC of the writing instruction
- md_valid  in  1  MDU result offered
- md_ready  out  1  MDU result accepted this cycle (valid&&ready = transfer)
- md_addr  in  AW  MDU destination register
- md_data  in  DW  MDU result
- md_pc  in  DW  PC of the MDU instruction
- grf_we  out  1  register file write enable
- grf_a3  out  AW  register file write address
- grf_wd  out  DW  register file write data
- grf_pc  out  DW  PC forwarded for the write trace
- q1_addr  in  AW  hazard query address 1 (rs)
- q2_addr  in  AW  hazard query address 2 (rt)
- q1_pend  out  1  q1_addr has an outstanding MDU write
- q2_pend  out  1  q2_addr has an outstanding MDU write
- q_count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: FIFO empty, q_count=0, all valid bits cleared. In the reset cycle md_ready=0, grf_we=0, q1_pend=q2_pend=0. A transfer in the reset cycle is lost; in-flight entries are discarded.
- Write-port select is combinational each cycle, in priority order:
  - wb_valid && wb_addr!=0 -> grf_we=1, grf_a3/wd/pc = wb_*.
  - else FIFO non-empty -> write the head entry, then pop it.
  - else md_valid && md_addr!=0 -> bypass: write md_* directly, zero latency, nothing enqueued.
  - else grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0.
- md_ready = !reset && (q_count<DEPTH || pop this cycle). If not bypassed, a transfer enqueues at the tail on the clock edge.
- Addr-0 handling:
  - md transfers with md_addr=0 are accepted and discarded.
  - wb requests with wb_addr=0 do not assert grf_we and do not block the FIFO.
- Ordering/kill:
  - When a wb write to address X (X!=0) occurs, every valid FIFO entry with addr X is invalidated on that edge, because the pipeline value is newer.
  - Invalid entries are popped without asserting grf_we (one cycle each).
  - An md transfer in the same cycle as a wb write to the same address is still enqueued; the MDU value is treated as younger.
- Pending flags:
  - qN_pend = qN_addr!=0 and (any valid FIFO entry has addr qN_addr, or an md transfer to qN_addr is enqueued this cycle).
  - The flag is combinational from current state and inputs.
  - An entry being written this cycle still counts as pending; the register file updates on the edge.
- Simultaneous push and pop when full is allowed; occupancy is unchanged. Pointers wrap modulo DEPTH.
- No gaps: FIFO order is strict; at most one register-file write per cycle.

Decomposition:
- Shared definitions package: AW/DW widths and the zero-register constant.
- One sub-module, grf_wq_fifo: DEPTH-entry circular buffer of {valid, addr, data, pc}. It provides push/pop, per-address kill, and a per-address match vector for the pend flags.
- Arbitration and bypass logic stay in the top module.

Test Plan:
- Bypass:
  - Stimulus: md_valid, addr 8, data 0x1234, no wb, FIFO empty.
  - Required: same cycle grf_we=1, a3=8, wd=0x1234; q_count stays 0; md_ready=1.
- Conflict:
  - Stimulus: wb (addr 3, 0xAAAA) and md (addr 9, 0xBBBB) in the same cycle.
  - Required: a3=3 written that cycle; md enqueued with q_count=1, q1_pend=1 for q1_addr=9. Next cycle a3=9, wd=0xBBBB, and q_count returns to 0.
- Full:
  - Stimulus: wb_valid held with addr 4 for 6 cycles; md offers 5 results to addrs 10..14.
  - Required: the first 4 are accepted, md_ready=0 on the 5th, q_count=4. After wb drops, writes to 10, 11, 12, 13, 14 follow in order, one per cycle, with no loss.
- Kill:
  - Stimulus: queue md addr 7 (0x7777) behind wb traffic, then wb writes addr 7 (0x5555).
  - Required: final register 7 = 0x5555; the killed entry pops with grf_we=0; q1_pend for addr 7 drops after the kill edge.
- Zero register:
  - Stimulus: md addr 0 with data 0xFFFF; wb addr 0.
  - Required: grf_we stays 0; md_ready=1; q_count unchanged; q1_pend=0 for q1_addr=0.
- Reset mid-queue:
  - Stimulus: 3 entries queued, then assert reset for 1 cycle.
  - Required: during the reset cycle md_ready=0 and grf_we=0. After reset q_count=0, pend flags 0, and none of the queued writes appear.
